traffic_light_monitor: RTL and testbench

Passive checker on the lamp outputs of the traffic light controller. It registers the red/yellow/green lines, decodes them back into phases and measures how long each phase lasts. It checks that phase order is RED → RED+YELLOW → GREEN → YELLOW → RED, that each phase lasts exactly its programmed duration, and that only legal lamp combinations appear. It is used as a bench checker and as an on-chip fault monitor next to the controller.

---
 rtl/traffic_light_monitor.sv | 230 +++++++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_light_monitor
//  Purpose  : Passive checker on the red/yellow/green lamp lines of a traffic
//             light controller. It decodes the lamps into phases, measures
//             how long each phase lasts, and reports three kinds of error:
//             illegal phase order, wrong dwell time and illegal lamp pattern.
//  Option   : TL_MON_SYNC_EN adds a 2-flop input synchronizer, for a
//             controller on an unrelated clock. Dwell checks then allow a
//             tolerance of +/-1 cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module traffic_light_monitor #(
    parameter int RED_T    = 20,
    parameter int REDYLW_T = 4,
    parameter int GREEN_T  = 20,
    parameter int YELLOW_T = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    output logic [1:0]       phase,
    output logic             phase_valid,
    output logic [CNT_W-1:0] dwell,
    output logic             err_seq,
    output logic             err_time,
    output logic             err_code,
    output logic             err_sticky,
    output logic [15:0]      cycles
);

    // Phase encodings
    localparam logic [1:0] c_ph_red    = 2'd0;
    localparam logic [1:0] c_ph_redylw = 2'd1;
    localparam logic [1:0] c_ph_green  = 2'd2;
    localparam logic [1:0] c_ph_yellow = 2'd3;

    // FSM states: INIT waits for a legal pattern, FREE times the first
    // (possibly truncated) phase, CHK fully checks every phase.
    localparam logic [1:0] c_s_init = 2'd0;
    localparam logic [1:0] c_s_free = 2'd1;
    localparam logic [1:0] c_s_chk  = 2'd2;

    localparam logic [CNT_W-1:0] c_dwell_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_dwell_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_red_t     = CNT_W'(RED_T);
    localparam logic [CNT_W-1:0] c_redylw_t  = CNT_W'(REDYLW_T);
    localparam logic [CNT_W-1:0] c_green_t   = CNT_W'(GREEN_T);
    localparam logic [CNT_W-1:0] c_yellow_t  = CNT_W'(YELLOW_T);

    logic [2:0] r_cur;
    logic       r_svld;

`ifdef TL_MON_SYNC_EN
    // Asynchronous lamps: one extra time of uncertainty on each dwell.
    localparam logic [CNT_W-1:0] c_tol = CNT_W'(1);

    logic [2:0] r_sync1;
    logic       r_vld1;

    // Two-flop synchronizer in front of the sample register; valid follows it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 3'b000;
            r_vld1  <= 1'b0;
            r_cur   <= 3'b000;
            r_svld  <= 1'b0;
        end else begin
            r_sync1 <= {red, yellow, green};
            r_vld1  <= 1'b1;
            r_cur   <= r_sync1;
            r_svld  <= r_vld1;
        end
    end
`else
    // Same clock as the controller: dwell checks are exact.
    localparam logic [CNT_W-1:0] c_tol = CNT_W'(0);

    // Single sample register; valid one cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur  <= 3'b000;
            r_svld <= 1'b0;
        end else begin
            r_cur  <= {red, yellow, green};
            r_svld <= 1'b1;
        end
    end
`endif

    logic [1:0]       r_state;
    logic [1:0]       r_phase;
    logic             r_pv;
    logic [CNT_W-1:0] r_dwell;
    logic             r_err_seq;
    logic             r_err_time;
    logic             r_err_code;
    logic             r_err_sticky;
    logic [15:0]      r_cycles;

    logic             w_legal;
    logic [1:0]       w_pat;
    logic [CNT_W-1:0] w_exp;
    logic [CNT_W-1:0] w_over_lim;
    logic             w_early;

    logic [1:0]       w_state_n;
    logic [1:0]       w_phase_n;
    logic             w_pv_n;
    logic [CNT_W-1:0] w_dwell_n;
    logic             w_seq_n;
    logic             w_time_n;
    logic             w_code_n;
    logic [15:0]      w_cycles_n;

    // Decode the sampled lamp pattern into a phase and a legality flag.
    always_comb begin
        w_legal = 1'b1;
        w_pat   = c_ph_red;
        case (r_cur)
            3'b100:  w_pat = c_ph_red;
            3'b110:  w_pat = c_ph_redylw;
            3'b001:  w_pat = c_ph_green;
            3'b010:  w_pat = c_ph_yellow;
            default: w_legal = 1'b0;
        endcase
    end

    // Expected dwell of the current phase and the derived overrun/early limits.
    // The early compare is one bit wider so a saturated dwell cannot wrap.
    always_comb begin
        case (r_phase)
            c_ph_red:    w_exp = c_red_t;
            c_ph_redylw: w_exp = c_redylw_t;
            c_ph_green:  w_exp = c_green_t;
            default:     w_exp = c_yellow_t;
        endcase
        w_over_lim = w_exp + c_tol;
        w_early    = ({1'b0, r_dwell} + {1'b0, c_tol}) < {1'b0, w_exp};
    end

    // Next-state logic of the checker FSM and its error pulses.
    always_comb begin
        w_state_n  = r_state;
        w_phase_n  = r_phase;
        w_pv_n     = r_pv;
        w_dwell_n  = r_dwell;
        w_seq_n    = 1'b0;
        w_time_n   = 1'b0;
        w_code_n   = 1'b0;
        w_cycles_n = r_cycles;
        if (r_svld) begin
            if (!w_legal) begin
                // Phase is kept so the last legal phase stays visible.
                w_code_n  = 1'b1;
                w_pv_n    = 1'b0;
                w_dwell_n = '0;
                w_state_n = c_s_init;
            end else if (r_state == c_s_init) begin
                w_phase_n = w_pat;
                w_dwell_n = c_dwell_one;
                w_pv_n    = 1'b1;
                w_state_n = c_s_free;
            end else if (w_pat == r_phase) begin
                if (r_dwell != c_dwell_max) begin
                    w_dwell_n = r_dwell + c_dwell_one;
                end
                // Fires once, on the step past the limit; a late end is not
                // reported again at the transition.
                if (r_dwell == w_over_lim) begin
                    w_time_n = 1'b1;
                end
            end else begin
                if (w_pat != (r_phase + 2'd1)) begin
                    w_seq_n = 1'b1;
                end
                // The first phase after INIT may have started before we saw
                // it, so only fully observed phases get the early-end check.
                if ((r_state == c_s_chk) && w_early) begin
                    w_time_n = 1'b1;
                end
                if ((r_phase == c_ph_yellow) && (w_pat == c_ph_red)) begin
                    w_cycles_n = r_cycles + 16'd1;
                end
                w_phase_n = w_pat;
                w_dwell_n = c_dwell_one;
                w_state_n = c_s_chk;
            end
        end
    end

    // Register FSM state and all outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_s_init;
            r_phase      <= c_ph_red;
            r_pv         <= 1'b0;
            r_dwell      <= '0;
            r_err_seq    <= 1'b0;
            r_err_time   <= 1'b0;
            r_err_code   <= 1'b0;
            r_err_sticky <= 1'b0;
            r_cycles     <= 16'd0;
        end else begin
            r_state      <= w_state_n;
            r_phase      <= w_phase_n;
            r_pv         <= w_pv_n;
            r_dwell      <= w_dwell_n;
            r_err_seq    <= w_seq_n;
            r_err_time   <= w_time_n;
            r_err_code   <= w_code_n;
            r_err_sticky <= r_err_sticky | w_seq_n | w_time_n | w_code_n;
            r_cycles     <= w_cycles_n;
        end
    end

    assign phase       = r_phase;
    assign phase_valid = r_pv;
    assign dwell       = r_dwell;
    assign err_seq     = r_err_seq;
    assign err_time    = r_err_time;
    assign err_code    = r_err_code;
    assign err_sticky  = r_err_sticky;
    assign cycles      = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_light_monitor
//  Purpose  : Self-checking bench for traffic_light_monitor. A table of lamp
//             segments {pattern, length} carries the expected error counts
//             and the phase/dwell/cycles seen after the segment's last sample.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_light_monitor;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             red, yellow, green;
    logic [1:0]       phase;
    logic             phase_valid;
    logic [CNT_W-1:0] dwell;
    logic             err_seq, err_time, err_code, err_sticky;
    logic [15:0]      cycles;

    always #5 clk = ~clk;

    traffic_light_monitor #(
        .RED_T(20), .REDYLW_T(4), .GREEN_T(20), .YELLOW_T(4), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .red(red), .yellow(yellow), .green(green),
        .phase(phase), .phase_valid(phase_valid), .dwell(dwell),
        .err_seq(err_seq), .err_time(err_time), .err_code(err_code),
        .err_sticky(err_sticky), .cycles(cycles)
    );

    typedef struct {
        logic [2:0] lamp;
        int         len;
        int         n_seq;
        int         n_time;
        int         n_code;
        int         ph;
        int         pv;
        int         dw;
        int         cyc;
    } vec_t;

    vec_t tbl[100];
    int   n_tbl = 0;
    int   acc_seq[100];
    int   acc_time[100];
    int   acc_code[100];
    int   total = 0;
    int   bad = 0;
    int   exp_sticky = 0;

    task automatic add(input logic [2:0] l, input int n, input int s, input int t,
                       input int c, input int p, input int v, input int d, input int y);
        tbl[n_tbl] = '{l, n, s, t, c, p, v, d, y};
        n_tbl++;
    endtask

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] l);
        {red, yellow, green} = l;
    endtask

    task automatic collect(input int idx);
        if (err_seq)  acc_seq[idx]++;
        if (err_time) acc_time[idx]++;
        if (err_code) acc_code[idx]++;
    endtask

    task automatic check_row(input int idx);
        if ((tbl[idx].n_seq + tbl[idx].n_time + tbl[idx].n_code) != 0) exp_sticky = 1;
        chk($sformatf("row%0d err_seq count", idx),  acc_seq[idx],  tbl[idx].n_seq);
        chk($sformatf("row%0d err_time count", idx), acc_time[idx], tbl[idx].n_time);
        chk($sformatf("row%0d err_code count", idx), acc_code[idx], tbl[idx].n_code);
        chk($sformatf("row%0d phase", idx),       int'(phase),       tbl[idx].ph);
        chk($sformatf("row%0d phase_valid", idx), int'(phase_valid), tbl[idx].pv);
        chk($sformatf("row%0d dwell", idx),       int'(dwell),       tbl[idx].dw);
        chk($sformatf("row%0d cycles", idx),      int'(cycles),      tbl[idx].cyc);
        chk($sformatf("row%0d err_sticky", idx),  int'(err_sticky),  exp_sticky);
    endtask

    // Outputs after a tick reflect the lamp driven one tick earlier, so each
    // observation is booked against the row of the previous lamp.
    task automatic run_table(input int first, input int last, input logic [2:0] flush);
        int prev;
        prev = -1;
        for (int r = first; r <= last; r++) begin
            acc_seq[r] = 0; acc_time[r] = 0; acc_code[r] = 0;
            for (int c = 0; c < tbl[r].len; c++) begin
                drive(tbl[r].lamp);
                tick();
                if (prev >= 0) begin
                    collect(prev);
                    if (c == 0) check_row(prev);
                end
                prev = r;
            end
        end
        drive(flush);
        tick();
        collect(prev);
        check_row(prev);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " phase"},       int'(phase),       0);
        chk({tag, " phase_valid"}, int'(phase_valid), 0);
        chk({tag, " dwell"},       int'(dwell),       0);
        chk({tag, " err_seq"},     int'(err_seq),     0);
        chk({tag, " err_time"},    int'(err_time),    0);
        chk({tag, " err_code"},    int'(err_code),    0);
        chk({tag, " err_sticky"},  int'(err_sticky),  0);
        chk({tag, " cycles"},      int'(cycles),      0);
    endtask

    initial begin
        int n1;
        // ---- Part 1: clean controller for 10 cycles, then corner cases ----
        for (int k = 0; k < 10; k++) begin
            add(3'b100, 20, 0, 0, 0, 0, 1, 20, k);
            add(3'b110,  4, 0, 0, 0, 1, 1,  4, k);
            add(3'b001, 20, 0, 0, 0, 2, 1, 20, k);
            add(3'b010,  4, 0, 0, 0, 3, 1,  4, k);
        end
        add(3'b100, 19, 0, 0, 0, 0, 1, 19, 10);  // short RED
        add(3'b110,  4, 0, 1, 0, 1, 1,  4, 10);  // early end flagged here
        add(3'b001, 20, 0, 0, 0, 2, 1, 20, 10);
        add(3'b010,  4, 0, 0, 0, 3, 1,  4, 10);
        add(3'b100, 25, 0, 1, 0, 0, 1, 25, 11);  // overrun at 20->21
        add(3'b110,  4, 0, 0, 0, 1, 1,  4, 11);  // late end not re-flagged
        add(3'b001, 20, 0, 0, 0, 2, 1, 20, 11);
        add(3'b010,  4, 0, 0, 0, 3, 1,  4, 11);
        add(3'b100, 20, 0, 0, 0, 0, 1, 20, 12);
        add(3'b001, 20, 1, 0, 0, 2, 1, 20, 12);  // RED -> GREEN skips REDYLW
        add(3'b010,  4, 0, 0, 0, 3, 1,  4, 12);
        add(3'b100, 20, 0, 0, 0, 0, 1, 20, 13);
        add(3'b110,  4, 0, 0, 0, 1, 1,  4, 13);
        add(3'b001, 10, 0, 0, 0, 2, 1, 10, 13);
        add(3'b101,  1, 0, 0, 1, 2, 0,  0, 13);  // illegal mid-GREEN
        add(3'b001,  5, 0, 0, 0, 2, 1,  5, 13);  // re-acquire, free-running
        add(3'b010,  4, 0, 0, 0, 3, 1,  4, 13);  // short GREEN not checked
        add(3'b100, 20, 0, 0, 0, 0, 1, 20, 14);
        add(3'b110,  4, 0, 0, 0, 1, 1,  4, 14);
        add(3'b001, 20, 0, 0, 0, 2, 1, 20, 14);
        add(3'b010,  4, 0, 0, 0, 3, 1,  4, 14);
        add(3'b100, 20, 0, 0, 0, 0, 1, 20, 15);
        add(3'b000,  2, 0, 0, 2, 0, 0,  0, 15);  // all dark, pulses each cycle
        add(3'b111,  1, 0, 0, 1, 0, 0,  0, 15);  // all lit
        add(3'b110,  3, 0, 0, 0, 1, 1,  3, 15);
        add(3'b001, 20, 0, 0, 0, 2, 1, 20, 15);
        add(3'b010,  4, 0, 0, 0, 3, 1,  4, 15);
        add(3'b100, 10, 0, 0, 0, 0, 1, 10, 16);
        add(3'b001, 20, 1, 1, 0, 2, 1, 20, 16);  // wrong order + early end
        add(3'b010,  4, 0, 0, 0, 3, 1,  4, 16);
        add(3'b100, 20, 0, 0, 0, 0, 1, 20, 17);
        n1 = n_tbl;
        // ---- Part 2: clean restart after mid-operation reset ----
        for (int k = 0; k < 2; k++) begin
            add(3'b100, 20, 0, 0, 0, 0, 1, 20, k);
            add(3'b110,  4, 0, 0, 0, 1, 1,  4, k);
            add(3'b001, 20, 0, 0, 0, 2, 1, 20, k);
            add(3'b010,  4, 0, 0, 0, 3, 1,  4, k);
        end
        add(3'b100, 20, 0, 0, 0, 0, 1, 20, 2);

        // Reset with the controller showing RED.
        rst = 1'b1;
        drive(3'b100);
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;
        run_table(0, n1 - 1, 3'b110);

        // Continue into mid-YELLOW with errors recorded, then reset.
        repeat (3) begin drive(3'b110); tick(); end
        repeat (20) begin drive(3'b001); tick(); end
        repeat (2) begin drive(3'b010); tick(); end
        chk("pre-rst phase",       int'(phase),       3);
        chk("pre-rst dwell",       int'(dwell),       1);
        chk("pre-rst phase_valid", int'(phase_valid), 1);
        chk("pre-rst err_sticky",  int'(err_sticky),  1);
        chk("pre-rst cycles",      int'(cycles),      17);
        rst = 1'b1;
        tick();
        check_zero("mid-rst");
        rst = 1'b0;
        exp_sticky = 0;
        run_table(n1, n_tbl - 1, 3'b110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
